// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencing controller: FSM with memory req/ack handshake and watchdog.
// Optional PERF_COUNTERS_EN adds cycle_count/instr_count outputs.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg2loc,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        instr_done,
  output logic [1:0]  fault,
  output logic [3:0]  state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_R   = 4'd6,
    S_WB_LD  = 4'd7,
    S_BRANCH = 4'd8,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_ILL  = 2'b01;
  localparam logic [1:0] FLT_TO   = 2'b10;

  state_t     state_q, state_d;
  logic [1:0] fault_q, fault_d;
  logic [7:0] wait_q, wait_d;

  logic is_rtype, is_ldur, is_stur, is_cbz, is_b;
  logic req_phase, timeout;

  always_comb begin
    is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
               (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
    is_ldur  = (opcode == 11'b11111000010);
    is_stur  = (opcode == 11'b11111000000);
    is_cbz   = (opcode[10:3] == 8'b10110100);
    is_b     = (opcode[10:5] == 6'b000101);
  end

  // Watchdog only runs while a memory request is outstanding.
  always_comb begin
    req_phase = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout   = req_phase && !mem_ack && (wait_q == TIMEOUT);
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
          fault_d = FLT_TO;
        end
      end
      S_DECODE: begin
        if (is_rtype) begin
          state_d = S_EXEC_R;
        end else if (is_ldur || is_stur) begin
          state_d = S_ADDR;
        end else if (is_cbz || is_b) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_FAULT;
          fault_d = FLT_ILL;
        end
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_ADDR:   state_d = is_stur ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ack) begin
          state_d = S_WB_LD;
        end else if (timeout) begin
          state_d = S_FAULT;
          fault_d = FLT_TO;
        end
      end
      S_MEM_WR: begin
        if (mem_ack) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
          fault_d = FLT_TO;
        end
      end
      S_WB_LD:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Counter restarts on ack and on any state change, so each new request phase begins at zero.
  always_comb begin
    if (req_phase && !mem_ack && (state_d == state_q)) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      fault_q <= FLT_NONE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  // During reset the outputs present the FETCH decode so no write strobe can escape.
  state_t st_eff;
  logic   ack_eff;

  always_comb begin
    st_eff  = reset ? S_FETCH : state_q;
    ack_eff = mem_ack && !reset;
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    case (st_eff)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = ack_eff;
      end
      S_DECODE: reg2loc = is_stur || is_cbz;
      S_EXEC_R: alu_op = 2'b10;
      S_WB_R: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDR: alu_src = 1'b1;
      S_MEM_RD: mem_req = 1'b1;
      S_WB_LD: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        alu_src    = 1'b1;
        pc_write   = ack_eff;
        instr_done = ack_eff;
      end
      S_BRANCH: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (is_cbz) begin
          reg2loc = 1'b1;
          alu_op  = 2'b01;
          pc_src  = zero;
        end else begin
          pc_src  = 1'b1;
        end
      end
      default: ;
    endcase
    fault = reset ? FLT_NONE : fault_q;
    state = st_eff;
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, instr_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      if (state_q != S_FAULT) cycle_count_q <= cycle_count_q + 32'd1;
      if (instr_done)         instr_count_q <= instr_count_q + 32'd1;
    end
  end

  always_comb begin
    cycle_count = cycle_count_q;
    instr_count = instr_count_q;
  end
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencing controller for the LEGv8 CPU datapath. Replaces the single-cycle combinational control with a state machine that breaks each instruction into fetch, decode, execute, memory and writeback cycles. It drives PC, instruction-register, register-bank, ALU and memory enables, and talks to a shared memory through a req/ack handshake with a watchdog. Decodes ADD, SUB, AND, ORR, LDUR, STUR, CBZ and B; any other opcode faults.

## Interface
- MEM_TIMEOUT, 16: maximum number of wait cycles without `mem_ack` before a fault; legal range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on `clk` rising edge.
- opcode  in  11  instruction bits [31:21] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag; combinational in the same cycle.
- mem_ack  in  1  memory completed the current request.
- mem_req  out  1  memory request; held high until ack.
- mem_we  out  1  1 = write request (STUR), 0 = read.
- ir_write  out  1  load instruction register (FETCH with ack).
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg2loc  out  1  register read port B selects ins[4:0].
- alu_src  out  1  ALU B = sign-extended immediate.
- alu_op  out  2  00 add, 01 pass B, 10 funct decode.
- mem_to_reg  out  1  writeback from memory data.
- reg_write  out  1  register bank write enable.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state  out  4  current state encoding (debug).

## Operation
- States: FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_LD=7, BRANCH=8, FAULT=15. Outputs are Moore-decoded from state, except `ir_write`, `pc_write` and `instr_done`, which are also qualified by `mem_ack` or `zero` where listed.
- FETCH: mem_req=1, mem_we=0. On ack: ir_write=1, go to DECODE. Otherwise stay.
- DECODE: reg2loc=1 for STUR and CBZ.
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000) goes to EXEC_R.
  - LDUR 11111000010 and STUR 11111000000 go to ADDR.
  - CBZ 10110100xxx and B 000101xxxxx go to BRANCH.
  - Anything else goes to FAULT with fault=01.
- EXEC_R: alu_op=10, alu_src=0, then WB_R.
- WB_R: reg_write=1, pc_write=1, pc_src=0, instr_done=1, then FETCH.
- ADDR: alu_op=00, alu_src=1, then MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_req=1, mem_we=0. On ack go to WB_LD.
- WB_LD: mem_to_reg=1, reg_write=1, pc_write=1, pc_src=0, instr_done=1, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, alu_src=1, alu_op=00. On ack: pc_write=1, pc_src=0, instr_done=1, then FETCH.
- BRANCH:
  - CBZ: reg2loc=1, alu_op=01, pc_write=1, pc_src=zero.
  - B: pc_write=1, pc_src=1.
  - Both assert instr_done=1, then FETCH.
- PC changes only on the last cycle of an instruction, so PC holds the current instruction address throughout.
- Watchdog:
  - 8-bit wait counter, cleared on entry to FETCH, MEM_RD and MEM_WR, and on every ack; increments each request cycle without ack.
  - When the counter equals MEM_TIMEOUT and there is no ack, go to FAULT with fault=10. An ack in that same cycle wins.
- FAULT: all enables 0, mem_req=0. `fault` holds its code until reset.
- `mem_ack` outside FETCH, MEM_RD and MEM_WR is ignored.

## Timing
- Reset values: state=FETCH, fault=00, wait counter=0, counters=0.
  - Output values during reset and in the first cycle after it are the FETCH decode: mem_req=1, mem_we=0, every other output 0.
- Latency in cycles, with single-cycle ack: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3. Each wait cycle adds 1 per memory phase.
- mem_req rises on state entry and stays high through the ack cycle. It falls the cycle after ack.
- Reset asserted mid-instruction:
  - The next state is FETCH and any pending request is abandoned.
  - No pc_write or reg_write occurs in the reset cycle.

## Configuration
- PERF_COUNTERS_EN defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0].
  - cycle_count increments every non-reset cycle while not in FAULT.
  - instr_count increments on each instr_done.
  - Both wrap from 0xFFFFFFFF to 0 and are cleared by reset.
- PERF_COUNTERS_EN undefined: the ports and logic are absent and all other behaviour is identical.

## Test plan
- Reset, then ADD (0x458) with immediate ack -> states 0,1,2,6. In state 6: reg_write=1, pc_write=1, pc_src=0, instr_done=1.
- LDUR (0x7C2) with ack delayed 3 cycles in MEM_RD -> 8 cycles total; mem_to_reg=1 and reg_write=1 only in WB_LD.
- CBZ (0x5A0) with zero=1 -> BRANCH asserts pc_src=1. With zero=0 -> pc_src=0. Both assert pc_write=1.
- Opcode 0x000 -> FAULT with fault=01; all enables stay 0 for 20 cycles; reset returns to FETCH with fault=00.
- MEM_TIMEOUT=4, FETCH with no ack -> FAULT, fault=10, after 5 cycles. Ack on the timeout cycle -> DECODE instead.
- PERF_COUNTERS_EN, 3 B instructions with immediate ack -> instr_count=3 and cycle_count=9; mid-run reset clears both to 0.
